dcache_data_array: RTL and testbench

DCACHE_DATA_ARRAY -- requirements
Module: dcache_data_array

---
 rtl/dcache_pkg.sv | 26 ++
 rtl/dcache_bank.sv | 48 ++++
 rtl/dcache_data_array.sv | 230 +++++++++++++++++++++++
 tb/tb_dcache_data_array.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// dcache_pkg
// Shared definitions for the data-cache data array: refill FSM state
// encoding, store-buffer age limit and word/byte geometry helpers.
// Imported by dcache_bank and dcache_data_array.
package dcache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_FLUSH = 2'd2
  } fill_state_e;

  // Store buffer is force-drained once it has been pending this many cycles.
  localparam int AGE_MAX = 4;
  localparam int AGE_W   = 3;

  localparam int BYTE_W     = 8;
  // Refill beats always start at word 0 of the line.
  localparam int FIRST_WORD = 0;

  // Select width that stays legal (>= 1 bit) for single-entry dimensions.
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dcache_bank.sv
// dcache_bank
// One word-wide slice of the data array: 2^INDEX_W entries of WORD_W bits,
// byte-granular write, registered read (data valid the cycle after en&!we).
// Ports:
//   clk, reset  clock / synchronous active-high reset (read register only)
//   en, we      access enable, write select
//   be          byte enables for writes
//   addr        set index
//   wdata       write word
//   rdata       read word, holds until the next read
module dcache_bank
  import dcache_pkg::*;
#(
  parameter int INDEX_W = 8,
  parameter int WORD_W  = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       we,
  input  logic [WORD_W/BYTE_W-1:0]   be,
  input  logic [INDEX_W-1:0]         addr,
  input  logic [WORD_W-1:0]          wdata,
  output logic [WORD_W-1:0]          rdata
);

  localparam int BE_W = WORD_W / BYTE_W;

  logic [WORD_W-1:0] mem [2**INDEX_W];

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int b = 0; b < BE_W; b++) begin
        if (be[b]) mem[addr][b*BYTE_W +: BYTE_W] <= wdata[b*BYTE_W +: BYTE_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dcache_data_array.sv
// dcache_data_array
// Set-associative data array: full-set line reads, a one-entry store buffer
// with byte enables and age-forced drain, and a word-per-beat refill path.
// One array access (read, refill write or store drain) per cycle.
// Optional build macro DCACHE_STORE_BYPASS_EN: reads hitting the buffered
// index are accepted and see the buffered bytes merged in; otherwise such a
// read stalls one cycle while the buffer drains.
// Ports:
//   clk, reset                        clock / synchronous active-high reset
//   rd_en, rd_ready, rd_index         line read request
//   rd_vld, rd_data                   read response, all ways of the set
//   st_valid, st_ready, st_way,
//   st_index, st_offset, st_data,
//   st_be                             store into the buffer
//   fill_valid, fill_ready, fill_way,
//   fill_index, fill_data             refill beats, word 0 first
//   fill_done                         pulse after the last beat is written
//
// state    | meaning
// ST_IDLE  | reads and store drains share the array
// ST_FILL  | accepting refill beats; reads and drains blocked
// ST_FLUSH | draining a store that targets the incoming refill line
module dcache_data_array
  import dcache_pkg::*;
#(
  parameter int WAYS    = 2,
  parameter int WORDS   = 4,
  parameter int INDEX_W = 8,
  parameter int WORD_W  = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             rd_en,
  output logic                             rd_ready,
  input  logic [INDEX_W-1:0]               rd_index,
  output logic                             rd_vld,
  output logic [WAYS*WORDS*WORD_W-1:0]     rd_data,
  input  logic                             st_valid,
  output logic                             st_ready,
  input  logic [sel_w(WAYS)-1:0]           st_way,
  input  logic [INDEX_W-1:0]               st_index,
  input  logic [sel_w(WORDS)-1:0]          st_offset,
  input  logic [WORD_W-1:0]                st_data,
  input  logic [WORD_W/BYTE_W-1:0]         st_be,
  input  logic                             fill_valid,
  output logic                             fill_ready,
  input  logic [sel_w(WAYS)-1:0]           fill_way,
  input  logic [INDEX_W-1:0]               fill_index,
  input  logic [WORD_W-1:0]                fill_data,
  output logic                             fill_done
);

  localparam int WAY_W  = sel_w(WAYS);
  localparam int OFF_W  = sel_w(WORDS);
  localparam int BE_W   = WORD_W / BYTE_W;
  localparam int DATA_W = WAYS * WORDS * WORD_W;

  fill_state_e state_q, state_d;

  logic [OFF_W-1:0]   beat_q;
  logic [WAY_W-1:0]   fway_q;
  logic [INDEX_W-1:0] fidx_q;

  logic               buf_vld_q;
  logic [WAY_W-1:0]   buf_way_q;
  logic [INDEX_W-1:0] buf_idx_q;
  logic [OFF_W-1:0]   buf_off_q;
  logic [WORD_W-1:0]  buf_data_q;
  logic [BE_W-1:0]    buf_be_q;
  // Counts down from AGE_MAX (age 0) to 0 (age AGE_MAX).
  logic [AGE_W-1:0]   age_tmr_q;

  logic               buf_hit_rd, fill_conflict, force_drain, rd_block;
  logic               drain, fill_we, rd_acc, st_acc, last_beat;
  logic [WAY_W-1:0]   beat_way;
  logic [INDEX_W-1:0] beat_idx;
  logic [INDEX_W-1:0] acc_idx;
  logic [BE_W-1:0]    wr_be;
  logic [WORD_W-1:0]  wr_data;
  logic [DATA_W-1:0]  arr_rdata;

  assign buf_hit_rd    = buf_vld_q && (buf_idx_q == rd_index);
  assign fill_conflict = buf_vld_q && (buf_way_q == fill_way) && (buf_idx_q == fill_index);
  assign force_drain   = buf_vld_q && (age_tmr_q == '0);
  assign last_beat     = (beat_q == OFF_W'(WORDS - 1));

`ifdef DCACHE_STORE_BYPASS_EN
  assign rd_block = 1'b0;
`else
  assign rd_block = buf_hit_rd;
`endif

  // Way/index are taken live on beat 0 and from the latched copy afterwards.
  assign beat_way = (beat_q == OFF_W'(FIRST_WORD)) ? fill_way   : fway_q;
  assign beat_idx = (beat_q == OFF_W'(FIRST_WORD)) ? fill_index : fidx_q;

  always_comb begin
    state_d    = state_q;
    rd_ready   = 1'b0;
    fill_ready = 1'b0;
    drain      = 1'b0;
    fill_we    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        rd_ready = !force_drain && !rd_block;
        drain    = buf_vld_q && (force_drain || !(rd_en && rd_ready));
        if (fill_valid) state_d = fill_conflict ? ST_FLUSH : ST_FILL;
      end
      ST_FLUSH: begin
        drain   = buf_vld_q;
        state_d = ST_FILL;
      end
      ST_FILL: begin
        fill_ready = 1'b1;
        fill_we    = fill_valid;
        if (fill_valid && last_beat) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rd_acc   = rd_en && rd_ready;
  assign st_ready = !buf_vld_q || drain;
  assign st_acc   = st_valid && st_ready;

  assign acc_idx = fill_we ? beat_idx : (drain ? buf_idx_q : rd_index);
  assign wr_be   = fill_we ? {BE_W{1'b1}} : buf_be_q;
  assign wr_data = fill_we ? fill_data : buf_data_q;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    for (genvar k = 0; k < WORDS; k++) begin : g_word
      logic bank_we;
      assign bank_we = (fill_we && (beat_way == WAY_W'(w)) && (beat_q == OFF_W'(k))) ||
                       (drain && (buf_way_q == WAY_W'(w)) && (buf_off_q == OFF_W'(k)));
      dcache_bank #(
        .INDEX_W (INDEX_W),
        .WORD_W  (WORD_W)
      ) u_bank (
        .clk   (clk),
        .reset (reset),
        .en    (bank_we || rd_acc),
        .we    (bank_we),
        .be    (wr_be),
        .addr  (acc_idx),
        .wdata (wr_data),
        .rdata (arr_rdata[(w*WORDS + k)*WORD_W +: WORD_W])
      );
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      beat_q    <= OFF_W'(FIRST_WORD);
      buf_vld_q <= 1'b0;
      age_tmr_q <= AGE_W'(AGE_MAX);
      rd_vld    <= 1'b0;
      fill_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_vld    <= rd_acc;
      fill_done <= fill_we && last_beat;
      if (fill_we) beat_q <= last_beat ? OFF_W'(FIRST_WORD) : beat_q + OFF_W'(1);
      if (st_acc) begin
        buf_vld_q <= 1'b1;
        age_tmr_q <= AGE_W'(AGE_MAX);
      end else if (drain) begin
        buf_vld_q <= 1'b0;
        age_tmr_q <= AGE_W'(AGE_MAX);
      end else if (buf_vld_q && age_tmr_q != '0) begin
        age_tmr_q <= age_tmr_q - AGE_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we && beat_q == OFF_W'(FIRST_WORD)) begin
      fway_q <= fill_way;
      fidx_q <= fill_index;
    end
    if (st_acc) begin
      buf_way_q  <= st_way;
      buf_idx_q  <= st_index;
      buf_off_q  <= st_offset;
      buf_data_q <= st_data;
      buf_be_q   <= st_be;
    end
  end

`ifdef DCACHE_STORE_BYPASS_EN
  // Buffer contents are captured with the read so the merged response keeps
  // holding after the buffer drains.
  logic              byp_hit_q;
  logic [WAY_W-1:0]  byp_way_q;
  logic [OFF_W-1:0]  byp_off_q;
  logic [WORD_W-1:0] byp_data_q;
  logic [BE_W-1:0]   byp_be_q;
  int                byp_lsb;

  always_ff @(posedge clk) begin
    if (reset) begin
      byp_hit_q <= 1'b0;
    end else if (rd_acc) begin
      byp_hit_q <= buf_hit_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_acc) begin
      byp_way_q  <= buf_way_q;
      byp_off_q  <= buf_off_q;
      byp_data_q <= buf_data_q;
      byp_be_q   <= buf_be_q;
    end
  end

  always_comb begin
    rd_data = arr_rdata;
    byp_lsb = (int'(byp_way_q) * WORDS + int'(byp_off_q)) * WORD_W;
    if (byp_hit_q) begin
      for (int b = 0; b < BE_W; b++) begin
        if (byp_be_q[b]) rd_data[byp_lsb + b*BYTE_W +: BYTE_W] = byp_data_q[b*BYTE_W +: BYTE_W];
      end
    end
  end
`else
  assign rd_data = arr_rdata;
`endif

endmodule

// File: tb/tb_dcache_data_array.sv
module tb_dcache_data_array;

  localparam int WAYS    = 2;
  localparam int WORDS   = 4;
  localparam int INDEX_W = 8;
  localparam int WORD_W  = 32;
  localparam int LINE_W  = WORDS * WORD_W;
  localparam int DATA_W  = WAYS * LINE_W;
`ifdef DCACHE_STORE_BYPASS_EN
  localparam int EXP_STALL = 0;
`else
  localparam int EXP_STALL = 1;
`endif

  logic               clk = 1'b0;
  logic               reset;
  logic               rd_en, rd_ready, rd_vld;
  logic [INDEX_W-1:0] rd_index;
  logic [DATA_W-1:0]  rd_data;
  logic               st_valid, st_ready;
  logic [0:0]         st_way;
  logic [INDEX_W-1:0] st_index;
  logic [1:0]         st_offset;
  logic [WORD_W-1:0]  st_data;
  logic [3:0]         st_be;
  logic               fill_valid, fill_ready, fill_done;
  logic [0:0]         fill_way;
  logic [INDEX_W-1:0] fill_index;
  logic [WORD_W-1:0]  fill_data;

  always #5 clk = ~clk;

  dcache_data_array #(
    .WAYS (WAYS), .WORDS (WORDS), .INDEX_W (INDEX_W), .WORD_W (WORD_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rd_en      (rd_en),
    .rd_ready   (rd_ready),
    .rd_index   (rd_index),
    .rd_vld     (rd_vld),
    .rd_data    (rd_data),
    .st_valid   (st_valid),
    .st_ready   (st_ready),
    .st_way     (st_way),
    .st_index   (st_index),
    .st_offset  (st_offset),
    .st_data    (st_data),
    .st_be      (st_be),
    .fill_valid (fill_valid),
    .fill_ready (fill_ready),
    .fill_way   (fill_way),
    .fill_index (fill_index),
    .fill_data  (fill_data),
    .fill_done  (fill_done)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_word(input string name, input logic [WORD_W-1:0] act, input logic [WORD_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_line(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_data(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(input logic way, input logic [7:0] idx, input logic [1:0] off,
                          input logic [31:0] data, input logic [3:0] be);
    int cyc;
    st_valid = 1'b1; st_way = way; st_index = idx; st_offset = off; st_data = data; st_be = be;
    cyc = 0;
    #1;
    while (!st_ready && cyc < 20) begin
      @(posedge clk); #2;
      cyc++;
    end
    chk_bit("store_accept", st_ready, 1'b1);
    @(posedge clk); #1;
    st_valid = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] idx, output logic [DATA_W-1:0] data, output int stalls);
    rd_en = 1'b1; rd_index = idx;
    stalls = 0;
    #1;
    while (!rd_ready && stalls < 20) begin
      @(posedge clk); #2;
      stalls++;
    end
    chk_bit("read_accept", rd_ready, 1'b1);
    @(posedge clk); #1;
    rd_en = 1'b0;
    chk_bit("read_vld", rd_vld, 1'b1);
    data = rd_data;
  endtask

  // Later-beat way/index are scrambled to prove the beat-0 values are held.
  task automatic do_fill(input logic way, input logic [7:0] idx, input logic [LINE_W-1:0] line,
                         output int cyc);
    int   b;
    logic acc;
    fill_valid = 1'b1; fill_way = way; fill_index = idx;
    b = 0; cyc = 0;
    while (b < WORDS && cyc < 40) begin
      fill_data = line[b*WORD_W +: WORD_W];
      #1;
      acc = fill_ready;
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        b++;
        fill_way   = ~way;
        fill_index = idx ^ 8'h5A;
      end
    end
    fill_valid = 1'b0;
    chk_int("fill_beats", b, WORDS);
    chk_bit("fill_done_pulse", fill_done, 1'b1);
    tick();
    chk_bit("fill_done_clear", fill_done, 1'b0);
  endtask

  typedef struct {
    logic        way;
    logic [7:0]  idx;
    logic [1:0]  off;
    logic [31:0] prior;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] exp;
  } st_vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    st_vec_t                tv[5];
    logic [LINE_W-1:0]      line_a, line_b, line_f, line_g, line_c;
    logic [DATA_W-1:0]      d, exp_d;
    int                     s, cyc, pos;

    tv[0] = '{1'b0, 8'h05, 2'd0, 32'h0000_0000, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF};
    tv[1] = '{1'b1, 8'h05, 2'd3, 32'hFFFF_FFFF, 32'h1234_5678, 4'b0001, 32'hFFFF_FF78};
    tv[2] = '{1'b0, 8'hFF, 2'd1, 32'h5555_5555, 32'hAAAA_AAAA, 4'b1000, 32'hAA55_5555};
    tv[3] = '{1'b1, 8'h00, 2'd2, 32'h0123_4567, 32'h89AB_CDEF, 4'b0000, 32'h0123_4567};
    tv[4] = '{1'b0, 8'h80, 2'd3, 32'hCAFE_F00D, 32'h0000_0000, 4'b0110, 32'hCA00_000D};

    line_a = {32'h1000_0003, 32'h1000_0002, 32'h1000_0001, 32'h1000_0000};
    line_b = {4{32'h1111_1111}};
    line_f = {32'h0000_00A3, 32'h0000_00A2, 32'h0000_00A1, 32'h0000_00A0};
    line_g = {32'hB000_0003, 32'hB000_0002, 32'hB000_0001, 32'hB000_0000};
    line_c = {32'hC000_0003, 32'hC000_0002, 32'hC000_0001, 32'hC000_0000};

    reset = 1'b1;
    rd_en = 1'b0; rd_index = '0;
    st_valid = 1'b0; st_way = '0; st_index = '0; st_offset = '0; st_data = '0; st_be = '0;
    fill_valid = 1'b0; fill_way = '0; fill_index = '0; fill_data = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk_bit("reset_rd_vld", rd_vld, 1'b0);
    chk_bit("reset_fill_done", fill_done, 1'b0);
    chk_data("reset_rd_data", rd_data, '0);
    chk_bit("reset_st_ready", st_ready, 1'b1);
    chk_bit("reset_rd_ready", rd_ready, 1'b1);
    chk_bit("reset_fill_ready", fill_ready, 1'b0);
    tick();

    // Preload set 0x10 and read both ways.
    do_fill(1'b0, 8'h10, line_a, cyc);
    chk_int("fill_cycles_idle", cyc, 5);
    do_fill(1'b1, 8'h10, line_b, cyc);
    do_read(8'h10, d, s);
    chk_data("read_set10", d, {line_b, line_a});
    chk_int("read_set10_stall", s, 0);
    tick();
    chk_bit("rd_vld_low", rd_vld, 1'b0);
    tick();
    chk_data("rd_data_hold", rd_data, {line_b, line_a});

    // Partial store over 0x11111111, then read the buffered index.
    do_store(1'b1, 8'h10, 2'd2, 32'hAABB_CCDD, 4'b0101);
    exp_d = {line_b, line_a};
    exp_d[(WORDS + 2)*WORD_W +: WORD_W] = 32'h11BB_11DD;
    do_read(8'h10, d, s);
    chk_data("store_read_buffered", d, exp_d);
    chk_int("store_read_stall", s, EXP_STALL);
    tick(); tick();
    do_read(8'h10, d, s);
    chk_data("store_read_drained", d, exp_d);
    chk_int("store_read_drained_stall", s, 0);

    // Table: full-word prior store, then byte-enabled store accepted on the
    // drain cycle of the first, then read the word.
    for (int i = 0; i < 5; i++) begin
      do_store(tv[i].way, tv[i].idx, tv[i].off, tv[i].prior, 4'b1111);
      do_store(tv[i].way, tv[i].idx, tv[i].off, tv[i].data, tv[i].be);
      do_read(tv[i].idx, d, s);
      pos = (int'(tv[i].way) * WORDS + int'(tv[i].off)) * WORD_W;
      chk_word($sformatf("vec%0d_word", i), d[pos +: WORD_W], tv[i].exp);
      chk_int($sformatf("vec%0d_stall", i), s, EXP_STALL);
    end

    // Refill with fill_done and word order.
    do_fill(1'b0, 8'h20, line_f, cyc);
    do_read(8'h20, d, s);
    chk_line("fill_line_0x20", d[LINE_W-1:0], line_f);

    // Store pending, refill to the same way/index goes through FLUSH.
    do_store(1'b1, 8'h30, 2'd1, 32'h9999_9999, 4'b1111);
    rd_en = 1'b1; rd_index = 8'h31;
    fill_valid = 1'b1; fill_way = 1'b1; fill_index = 8'h30; fill_data = line_g[WORD_W-1:0];
    #1;
    chk_bit("conflict_fill_ready", fill_ready, 1'b0);
    chk_bit("conflict_rd_ready", rd_ready, 1'b1);
    @(posedge clk); #1;
    rd_en = 1'b0;
    #1;
    chk_bit("flush_fill_ready", fill_ready, 1'b0);
    chk_bit("flush_rd_ready", rd_ready, 1'b0);
    chk_bit("flush_st_ready", st_ready, 1'b1);
    @(posedge clk); #1;
    do_fill(1'b1, 8'h30, line_g, cyc);
    chk_int("flush_then_fill_cycles", cyc, 4);
    do_read(8'h30, d, s);
    chk_line("flush_line_0x30", d[DATA_W-1:LINE_W], line_g);
    chk_int("flush_read_stall", s, 0);

    // Continuous reads elsewhere: drain forced at age 4.
    rd_en = 1'b1; rd_index = 8'h41;
    st_valid = 1'b1; st_way = 1'b0; st_index = 8'h40; st_offset = 2'd0;
    st_data = 32'h7777_7777; st_be = 4'b1111;
    #1;
    chk_bit("age_store_ready", st_ready, 1'b1);
    @(posedge clk); #1;
    st_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk_bit($sformatf("age%0d_rd_ready", i), rd_ready, (i == 4) ? 1'b0 : 1'b1);
      @(posedge clk); #1;
    end
    rd_en = 1'b0;
    do_read(8'h40, d, s);
    chk_word("forced_drain_word", d[WORD_W-1:0], 32'h7777_7777);
    chk_int("forced_drain_stall", s, 0);

    // Reset in the middle of a refill with a store pending.
    do_fill(1'b1, 8'h50, line_c, cyc);
    fill_valid = 1'b1; fill_way = 1'b1; fill_index = 8'h50; fill_data = 32'hD000_0000;
    tick();
    tick();
    fill_data = 32'hD000_0001;
    st_valid = 1'b1; st_way = 1'b1; st_index = 8'h50; st_offset = 2'd3;
    st_data = 32'hEEEE_EEEE; st_be = 4'b1111;
    #1;
    chk_bit("midfill_st_ready", st_ready, 1'b1);
    @(posedge clk); #1;
    st_valid = 1'b0; fill_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk_bit("rst2_rd_vld", rd_vld, 1'b0);
    chk_bit("rst2_fill_done", fill_done, 1'b0);
    chk_data("rst2_rd_data", rd_data, '0);
    chk_bit("rst2_fill_ready", fill_ready, 1'b0);
    chk_bit("rst2_st_ready", st_ready, 1'b1);
    @(posedge clk); #1;
    chk_bit("rst2_no_fill_done", fill_done, 1'b0);
    do_read(8'h50, d, s);
    chk_line("partial_line_0x50", d[DATA_W-1:LINE_W],
             {32'hC000_0003, 32'hC000_0002, 32'hD000_0001, 32'hD000_0000});
    chk_int("partial_line_stall", s, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
